// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter
// Parallel-in, serial-out frame transmitter. A WIDTH-bit word accepted through
// the load/ready handshake is sent on tx as a start bit (0), the data bits
// LSB-first, an optional even-parity bit and a stop bit (1). Every bit is held
// for CLKS_PER_BIT clocks. All state changes on the falling edge of clk.
// Build option: define SER_TX_PARITY_EN to insert the parity bit after the data.
module serial_frame_transmitter #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SER_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shifted;
`ifdef SER_TX_PARITY_EN
    logic               parity_bit;
`endif

    // Next contents of the shift register once the current data bit is finished
    always_comb begin
        shifted = shift_reg >> 1;
    end

    // Frame sequencer: accepts a word, times each bit and drives the registered outputs
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SER_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    shift_reg <= data_in;
`ifdef SER_TX_PARITY_EN
                    parity_bit <= ^data_in;
`endif
                    state     <= START;
                    tx        <= 1'b0;
                    ready     <= 1'b0;
                    busy      <= 1'b1;
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                end
            end else if (cycle_cnt != CNT_LAST) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end else begin
                cycle_cnt <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SER_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            shift_reg <= shifted;
                            tx        <= shifted[0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
`ifdef SER_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb_serial_frame_transmitter
// Drives two transmitters (CLKS_PER_BIT=4 and CLKS_PER_BIT=1) with directed
// frames. A frame-position model predicts tx/ready/busy/done every cycle, and
// literal frame patterns pin the model for the directed cases.
module tb_serial_frame_transmitter;

    localparam int W = 8;
`ifdef SER_TX_PARITY_EN
    localparam int PAR = 1;
    localparam logic [11:0] EXP_A5 = 12'h54A;
    localparam logic [11:0] EXP_07 = 12'h60E;
    localparam logic [11:0] EXP_3C = 12'h478;
    localparam logic [11:0] EXP_81 = 12'h502;
    localparam logic [11:0] EXP_00 = 12'h400;
    localparam logic [11:0] EXP_FF = 12'h5FE;
    localparam logic [11:0] EXP_55 = 12'h4AA;
    localparam int LEN4 = 44;
    localparam int LEN1 = 11;
`else
    localparam int PAR = 0;
    localparam logic [11:0] EXP_A5 = 12'h34A;
    localparam logic [11:0] EXP_07 = 12'h20E;
    localparam logic [11:0] EXP_3C = 12'h278;
    localparam logic [11:0] EXP_81 = 12'h302;
    localparam logic [11:0] EXP_00 = 12'h200;
    localparam logic [11:0] EXP_FF = 12'h3FE;
    localparam logic [11:0] EXP_55 = 12'h2AA;
    localparam int LEN4 = 40;
    localparam int LEN1 = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0] load_v;
    logic [1:0][7:0] data_v;
    wire  [1:0] tx_v;
    wire  [1:0] ready_v;
    wire  [1:0] busy_v;
    wire  [1:0] done_v;

    int total = 0;
    int bad = 0;

    logic       m_active [2] = '{1'b0, 1'b0};
    int         m_pos    [2] = '{0, 0};
    logic       m_done   [2] = '{1'b0, 1'b0};
    logic [7:0] m_word   [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_v[0]), .load(load_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    serial_frame_transmitter #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_fast (
        .clk(clk), .rst(rst), .data_in(data_v[1]), .load(load_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    function automatic int cpb(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int frameLen(input int k);
        return (W + 2 + PAR) * cpb(k);
    endfunction

    // Value of bit number idx of the frame: start, data LSB-first, parity, stop
    function automatic logic frameBit(input logic [7:0] word, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= W) return word[idx-1];
        if (PAR == 1 && idx == W + 1) return ^word;
        return 1'b1;
    endfunction

    // Model: tracks position within the current frame, advancing on each falling edge
    always @(negedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] <= 1'b0;
                m_pos[k]    <= 0;
                m_done[k]   <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_active[k]) begin
                    if (m_pos[k] + 1 == frameLen(k)) begin
                        m_active[k] <= 1'b0;
                        m_done[k]   <= 1'b1;
                    end else begin
                        m_pos[k] <= m_pos[k] + 1;
                    end
                end else if (load_v[k]) begin
                    m_active[k] <= 1'b1;
                    m_pos[k]    <= 0;
                    m_word[k]   <= data_v[k];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] word);
        @(posedge clk);
        #1;
        load_v[k] = 1'b1;
        data_v[k] = word;
        @(negedge clk);
        #1;
        load_v[k] = 1'b0;
    endtask

    // Samples tx at the first cycle of each bit until done, bounded
    task automatic captureFrame(input int k, output logic [11:0] bits, output int done_at);
        bits = '0;
        done_at = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (done_v[k]) begin
                done_at = i;
                break;
            end
            if (i % cpb(k) == 0 && i / cpb(k) < 12) bits[i / cpb(k)] = tx_v[k];
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("tx%0d", k), 32'(tx_v[k]),
                            32'(m_active[k] ? frameBit(m_word[k], m_pos[k] / cpb(k)) : 1'b1));
                checkOutput($sformatf("ready%0d", k), 32'(ready_v[k]), 32'(!m_active[k]));
                checkOutput($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(m_active[k]));
                checkOutput($sformatf("done%0d", k), 32'(done_v[k]), 32'(m_done[k]));
            end
        end
    endtask

    initial begin
        logic [11:0] bits;
        logic [11:0] bits2;
        int done_at;
        int done_at2;

        rst = 1'b1;
        load_v = '0;
        data_v = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", 32'(tx_v[0]), 32'd1);
        checkOutput("reset_ready", 32'(ready_v[0]), 32'd1);
        checkOutput("reset_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("reset_done", 32'(done_v[0]), 32'd0);
        rst = 1'b0;
        fork
            compareLoop();
        join_none
        repeat (2) @(posedge clk);

        $display("[TB] basic frame 8'hA5");
        applyStimulus(0, 8'hA5);
        captureFrame(0, bits, done_at);
        checkOutput("a5_bits", 32'(bits), 32'(EXP_A5));
        checkOutput("a5_done_at", done_at, LEN4);
        @(posedge clk);
        checkOutput("a5_ready_after", 32'(ready_v[0]), 32'd1);

        $display("[TB] frame 8'h07");
        applyStimulus(0, 8'h07);
        captureFrame(0, bits, done_at);
        checkOutput("h07_bits", 32'(bits), 32'(EXP_07));
        checkOutput("h07_done_at", done_at, LEN4);

        $display("[TB] load ignored while busy");
        applyStimulus(0, 8'h3C);
        fork
            captureFrame(0, bits, done_at);
            begin
                repeat (10) @(posedge clk);
                #1;
                load_v[0] = 1'b1;
                data_v[0] = 8'hFF;
                @(negedge clk);
                #1;
                load_v[0] = 1'b0;
            end
        join
        checkOutput("h3c_bits", 32'(bits), 32'(EXP_3C));
        checkOutput("h3c_done_at", done_at, LEN4);
        repeat (6) @(posedge clk);
        checkOutput("h3c_no_second", 32'(busy_v[0]), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'hF0);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", 32'(tx_v[0]), 32'd1);
        checkOutput("midrst_ready", 32'(ready_v[0]), 32'd1);
        checkOutput("midrst_busy", 32'(busy_v[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 8'h81);
        captureFrame(0, bits, done_at);
        checkOutput("h81_bits", 32'(bits), 32'(EXP_81));
        checkOutput("h81_done_at", done_at, LEN4);

        $display("[TB] back-to-back frames");
        repeat (2) @(posedge clk);
        #1;
        load_v[0] = 1'b1;
        data_v[0] = 8'h00;
        @(negedge clk);
        #1;
        data_v[0] = 8'hFF;
        captureFrame(0, bits, done_at);
        checkOutput("b2b_first_bits", 32'(bits), 32'(EXP_00));
        checkOutput("b2b_first_done_at", done_at, LEN4);
        checkOutput("b2b_gap_tx", 32'(tx_v[0]), 32'd1);
        fork
            captureFrame(0, bits2, done_at2);
            begin
                @(negedge clk);
                #1;
                load_v[0] = 1'b0;
            end
        join
        checkOutput("b2b_second_bits", 32'(bits2), 32'(EXP_FF));
        checkOutput("b2b_second_done_at", done_at2, LEN4);

        $display("[TB] one clock per bit, 8'h55");
        applyStimulus(1, 8'h55);
        captureFrame(1, bits, done_at);
        checkOutput("fast_bits", 32'(bits), 32'(EXP_55));
        checkOutput("fast_done_at", done_at, LEN1);

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
